// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_adder_pkg : shared state encoding and counter-width helper |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter must stay at least one bit wide so the N=1 compare still exists.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fulladder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fulladder : one-bit full adder cell (carry-out, sum, cin, a, b)    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fulladder (
  output logic rout,
  output logic som,
  input  logic rin,
  input  logic a,
  input  logic b
);

  assign som  = a ^ b ^ rin;
  assign rout = (a & b) | (rin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_adder : bit-serial N-bit unsigned adder, LSB first          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned   CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         r_state;
  logic [N-1:0]   r_a_sh;
  logic [N-1:0]   r_b_sh;
  logic [N-1:0]   r_s_sh;
  logic [N-1:0]   r_sum;
  logic           r_carry;
  logic           r_cout;
  logic [CW-1:0]  r_cnt;

  logic           w_som;
  logic           w_rout;
  logic [N-1:0]   w_s_next;

  fulladder u_fa (
    .rout (w_rout),
    .som  (w_som),
    .rin  (r_carry),
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0])
  );

  // New sum bit enters at the MSB; the shift form also covers N=1.
  assign w_s_next = N'({w_som, r_s_sh} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_s_sh  <= w_s_next;
          r_carry <= w_rout;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_sum   <= w_s_next;
            r_cout  <= w_rout;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready = (r_state != ST_RUN);
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign sum   = r_sum;
  assign cout  = r_cout;

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit unsigned adder built around the team's existing one-bit `fulladder` cell.
- Each operation loads two operands and a carry-in, then feeds one bit pair per clock through the cell, LSB first.
- The carry is kept in a flip-flop between bits, and the assembled sum and final carry are presented with a done pulse.
- Sits directly downstream of the `fulladder` cell. It is the sequential datapath stage that consumes the cell's `rout`/`som` outputs.

Parameters:
- N, 8, operand/sum width in bits; legal range N >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new addition; sampled only when ready=1.
- a  input  N  operand A, captured on the accepting edge.
- b  input  N  operand B, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- ready  output  1  block can accept start this cycle.
- busy  output  1  serial addition in progress.
- done  output  1  one-cycle pulse: sum/cout just updated.
- sum  output  N  result register, A+B+cin mod 2^N.
- cout  output  1  carry out of bit N-1.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately regardless of clk):
  - state=IDLE; ready=1; busy=0; done=0; sum=0; cout=0.
  - Shift registers, carry FF and bit counter are all cleared.
- Reset mid-operation discards the partial result; no done pulse is produced for it.
- FSM states: IDLE, RUN, DONE.
  - ready = (state != RUN).
  - busy = (state == RUN).
  - done = (state == DONE).
- IDLE, or DONE, with start=1 at an edge (call it T0):
  - a_sh<=a; b_sh<=b; carry<=cin; cnt<=0.
  - Next state is RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, at each edge:
  - Cell inputs are a_sh[0], b_sh[0] and carry.
  - s_sh <= {som, s_sh[N-1:1]}; carry <= rout.
  - a_sh and b_sh shift right by 1; cnt <= cnt+1.
- RUN, on the edge where cnt==N-1 (edge T0+N):
  - sum <= final shifted value; cout <= rout.
  - Next state is DONE.
- Latency:
  - done=1 exactly during the cycle between edges T0+N and T0+N+1.
  - sum/cout change only at edge T0+N and hold until the next completion.
- Throughput: with start held high, one operation per N+1 cycles. A start sampled in DONE is accepted back-to-back.
- start during RUN is ignored: no queueing, no restart.
- Changes to a, b or cin after the accepting edge have no effect.
- Width rules:
  - Unsigned arithmetic; overflow is reported only through cout.
  - cnt width is clog2(N), minimum 1. The cnt==N-1 compare must hold for N=1, where RUN lasts one cycle.
- No X on any output after reset; all outputs are registered or decoded from the registered state.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - a counter-width helper function.
- One sub-module instance: the existing `fulladder` cell, port order (carry-out, sum, carry-in, a, b).
- FSM, shift registers and carry FF live in serial_adder itself.

Test Plan:
- N=8, a=0x00, b=0x00, cin=1 -> done at T0+8 edge; sum=0x01, cout=0; busy=1 for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- a=0x35, b=0x4A, cin=0; during RUN, drive a=0xAA, b=0x55 and pulse start -> sum=0x7F, cout=0; exactly one done pulse; extra start ignored.
- Start a=0x12, b=0x34; assert rst_n=0 mid-cycle on the 4th RUN cycle:
  - all outputs go to 0 / ready=1 immediately, without waiting for clk;
  - no done pulse;
  - after release, 0x12+0x34 gives sum=0x46, cout=0.
- start held high with a=0x80, b=0x80, cin=0, then a=0x0F, b=0x01, cin=0 presented in the DONE cycle:
  - first result sum=0x00, cout=1; second result sum=0x10, cout=0;
  - done pulses exactly 9 cycles apart.
- N=1 instance: a=1, b=1, cin=1 -> sum=1, cout=1; done one edge after RUN entry.
